uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer directly downstream of the UART receiver.
//  - Captures each received byte on the receiver's one-cycle data-valid pulse.
//  - Holds bytes in a DEPTH-entry circular FIFO; the bus/register side drains it by popping.
//  - Reports level, full/empty, sticky overflow, a watermark interrupt and an optional idle-timeout interrupt.
// PARAMETERS
//  DEPTH  16  FIFO entries; power of two, >= 4
//  AW     4   address width, clog2(DEPTH); level fields are AW+1 bits
// PORTS
//  i_Clock           in   1     system clock
//  rst_ni            in   1     reset, asynchronous, active-low
//  i_rx_dv           in   1     byte-valid pulse from receiver (1 cycle per byte)
//  i_rx_byte         in   8     received byte, valid while i_rx_dv=1
//  i_rd_en           in   1     pop request from register side
//  o_rd_data         out  8     head byte (first-word fall-through); 8'h00 when empty
//  o_empty           out  1     level==0
//  o_full            out  1     level==DEPTH
//  o_level           out  AW+1  bytes held, 0..DEPTH
//  i_thresh          in   AW+1  watermark; 0 disables o_thresh_irq
//  o_thresh_irq      out  1     registered: level>=i_thresh && i_thresh!=0
//  o_overflow        out  1     sticky: a byte was dropped because the FIFO was full
//  i_clr_ovf         in   1     clears o_overflow
//  i_flush           in   1     empties the FIFO
//  i_timeout_cycles  in   16    idle-timeout limit in clocks; 0 disables
//  o_timeout_irq     out  1     idle timeout (0 when UART_RX_TIMEOUT_EN is not defined)
// BEHAVIOUR
//  - Reset (async, rst_ni=0): wr_ptr=rd_ptr=0; level=0; o_empty=1; o_full=0; o_overflow=0; both IRQs=0; timeout counter=0.
//    Memory contents are not reset; o_rd_data=8'h00 because the FIFO is empty.
//  - Push: when i_rx_dv=1 and the FIFO is not full, write mem[wr_ptr] and increment wr_ptr (mod DEPTH).
//    The byte is visible on o_rd_data and o_level on the next cycle.
//  - Pop: when i_rd_en=1 and o_empty=0, increment rd_ptr (mod DEPTH).
//    o_rd_data = mem[rd_ptr], read combinationally from the registered pointer. i_rd_en while empty is ignored.
//  - Push and pop in the same cycle:
//    - Not empty: both are performed; level is unchanged.
//    - Full: the pop frees a slot, so the push is accepted; level stays DEPTH and no overflow is flagged.
//    - Empty: the pop is ignored and the push is accepted; level becomes 1.
//  - Overflow: i_rx_dv=1 while full and with no same-cycle pop -> the byte is dropped, the FIFO is unchanged, and o_overflow=1 next cycle.
//    i_clr_ovf clears o_overflow; if set and clear occur in the same cycle, set wins.
//  - Flush: i_flush=1 has highest priority. Next cycle the pointers and level are 0.
//    A same-cycle push or pop is discarded, and the timeout counter and o_timeout_irq are cleared. o_overflow is unaffected.
//  - Pointers wrap modulo DEPTH. Full/empty come from a separate AW+1-bit level counter, not from pointer comparison.
//  - o_thresh_irq is registered from the next-state level: 1-cycle latency after the level change. It is level-sensitive, not sticky.
//  - Single clock domain. Input i_rx_dv is already synchronous to i_Clock.
// CONFIGURATION
//  Macro UART_RX_TIMEOUT_EN.
//  - Defined:
//    - A 16-bit counter increments each clock while level!=0 and there is no push, pop or flush.
//    - Any push, pop or flush clears it to 0. It saturates at 16'hFFFF.
//    - When counter==i_timeout_cycles and i_timeout_cycles!=0, o_timeout_irq is set next cycle.
//    - o_timeout_irq is sticky until the next pop, flush or reset. A push does not clear it.
//  - Not defined:
//    - No counter logic; o_timeout_irq is tied to 1'b0; i_timeout_cycles is unused.
//    - Ports are identical in both builds.
// TESTING
//  T1 Reset: hold rst_ni=0 mid-traffic with level=5 -> o_empty=1, o_level=0, o_overflow=0, IRQs=0 immediately; after release, popping is ignored.
//  T2 Order: push A5,3C,7E -> o_level=3, o_rd_data=A5; pop x3 -> 3C, 7E, then o_empty=1 and o_rd_data=00.
//  T3 Overflow: push 00..0F (16 bytes), then push FF -> o_full=1, o_overflow=1, o_level=16.
//     Drain 16 bytes -> 00..0F with no FF. i_clr_ovf=1 -> o_overflow=0.
//  T4 Full push+pop: with the FIFO full of 00..0F, push 55 and pop in the same cycle -> o_level=16, o_overflow=0.
//     Drain -> 01..0F then 55. Repeat across a pointer wrap with the same result.
//  T5 Watermark: i_thresh=4, push 4 bytes -> o_thresh_irq=1 one cycle after the 4th push. Pop 1 -> o_thresh_irq=0 one cycle later.
//     i_thresh=0 -> never asserted.
//  T6 Timeout (UART_RX_TIMEOUT_EN defined): i_timeout_cycles=100, push 1 byte, idle -> o_timeout_irq rises 101 cycles after the push.
//     A second push keeps it 1; pop -> 0. Without the macro, the same stimulus leaves o_timeout_irq=0 throughout.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO placed after a UART receiver, with level, overflow and irq reporting
//   i_Clock, rst_ni (async, active-low)
//   i_rx_dv/i_rx_byte  : one-cycle byte strobe from the receiver (push)
//   i_rd_en            : pop request; o_rd_data is the first-word fall-through head (8'h00 when empty)
//   o_empty/o_full/o_level : occupancy, from a dedicated AW+1-bit level counter
//   i_thresh/o_thresh_irq  : registered watermark irq, 0 disables
//   o_overflow/i_clr_ovf   : sticky drop flag and its clear (set wins)
//   i_flush                : empties the FIFO, highest priority
//   i_timeout_cycles/o_timeout_irq : idle timeout, only built when UART_RX_TIMEOUT_EN is defined
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_Clock,
  input  logic          rst_ni,
  input  logic          i_rx_dv,
  input  logic [7:0]    i_rx_byte,
  input  logic          i_rd_en,
  output logic [7:0]    o_rd_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_level,
  input  logic [AW:0]   i_thresh,
  output logic          o_thresh_irq,
  output logic          o_overflow,
  input  logic          i_clr_ovf,
  input  logic          i_flush,
  input  logic [15:0]   i_timeout_cycles,
  output logic          o_timeout_irq
);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level, w_level_nxt;
  logic          r_ovf, r_thresh_irq;
  logic          w_pop, w_push, w_drop;
  assign o_empty   = r_level == '0;
  assign o_full    = r_level == L_FULL;
  assign o_level   = r_level;
  assign o_rd_data = o_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign o_overflow   = r_ovf;
  assign o_thresh_irq = r_thresh_irq;
  assign w_pop  = i_rd_en && !o_empty;
  // a same-cycle pop frees the slot, so a full FIFO still accepts the byte
  assign w_push = i_rx_dv && (!o_full || w_pop);
  assign w_drop = i_rx_dv && o_full && !w_pop && !i_flush;
  assign w_level_nxt = i_flush ? '0 : r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_ovf        <= 1'b0;
      r_thresh_irq <= 1'b0;
    end else begin
      r_wr_ptr     <= i_flush ? '0 : r_wr_ptr + AW'(w_push);
      r_rd_ptr     <= i_flush ? '0 : r_rd_ptr + AW'(w_pop);
      r_level      <= w_level_nxt;
      r_ovf        <= w_drop || (r_ovf && !i_clr_ovf);
      r_thresh_irq <= (i_thresh != '0) && (w_level_nxt >= i_thresh);
    end
  end
  // storage is deliberately not reset; emptiness masks stale contents
  always_ff @(posedge i_Clock) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_rx_byte;
  end
`ifdef UART_RX_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_tmo_irq;
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
      r_tmo_irq <= 1'b0;
    end else begin
      r_tmo_cnt <= (i_flush || w_push || w_pop) ? '0 :
                   (r_level != '0 && r_tmo_cnt != 16'hFFFF) ? r_tmo_cnt + 16'd1 : r_tmo_cnt;
      // sticky until a pop or flush; pushes only restart the idle count
      r_tmo_irq <= (i_flush || w_pop) ? 1'b0 :
                   (i_timeout_cycles != '0 && r_tmo_cnt == i_timeout_cycles) ? 1'b1 : r_tmo_irq;
    end
  end
  assign o_timeout_irq = r_tmo_irq;
`else
  logic w_unused_tmo;
  assign w_unused_tmo  = ^i_timeout_cycles;
  assign o_timeout_irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table, directed corner sequences and queue-model random checks for uart_rx_fifo
module tb_uart_rx_fifo;
  logic        i_Clock = 1'b0;
  logic        rst_ni;
  logic        i_rx_dv, i_rd_en, i_clr_ovf, i_flush;
  logic [7:0]  i_rx_byte, o_rd_data;
  logic [4:0]  i_thresh, o_level;
  logic [15:0] i_timeout_cycles;
  logic        o_empty, o_full, o_thresh_irq, o_overflow, o_timeout_irq;
`ifdef UART_RX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  uart_rx_fifo dut (
    .i_Clock(i_Clock), .rst_ni(rst_ni), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_empty(o_empty), .o_full(o_full),
    .o_level(o_level), .i_thresh(i_thresh), .o_thresh_irq(o_thresh_irq),
    .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf), .i_flush(i_flush),
    .i_timeout_cycles(i_timeout_cycles), .o_timeout_irq(o_timeout_irq)
  );
  always #5 i_Clock = ~i_Clock;
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] q[$];
  bit m_ovf, m_thr;
  typedef struct {
    bit rx; logic [7:0] b; bit rd; bit fl;
    logic [4:0] lvl; logic [7:0] data; bit thr;
  } vec_t;
  vec_t tv[11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic model();
    bit pop, set;
    pop = i_rd_en && q.size() != 0;
    set = 1'b0;
    if (i_flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (i_rx_dv) begin
        if (q.size() < 16) q.push_back(i_rx_byte);
        else set = 1'b1;
      end
    end
    m_ovf = set || (m_ovf && !i_clr_ovf);
    m_thr = i_thresh != 0 && q.size() >= int'(i_thresh);
  endtask
  task automatic tick();
    model();
    @(posedge i_Clock);
    #1;
  endtask
  task automatic idle_inputs();
    i_rx_dv = 0; i_rx_byte = 0; i_rd_en = 0; i_clr_ovf = 0; i_flush = 0;
  endtask
  task automatic do_reset();
    rst_ni = 0;
    idle_inputs();
    q.delete(); m_ovf = 0; m_thr = 0;
    @(posedge i_Clock); #1;
    rst_ni = 1;
  endtask
  task automatic push(input logic [7:0] b);
    i_rx_dv = 1; i_rx_byte = b; tick(); i_rx_dv = 0;
  endtask
  task automatic pop();
    i_rd_en = 1; tick(); i_rd_en = 0;
  endtask
  task automatic chk_model();
    chk("level", o_level, q.size());
    chk("empty", o_empty, q.size() == 0);
    chk("full", o_full, q.size() == 16);
    chk("data", o_rd_data, q.size() != 0 ? q[0] : 8'h00);
    chk("ovf", o_overflow, m_ovf);
    chk("thr", o_thresh_irq, m_thr);
    chk("tmo", o_timeout_irq, 0);
  endtask
  initial begin
    int pr;
    i_thresh = 0; i_timeout_cycles = 0;
    do_reset();
    chk("rst_empty", o_empty, 1);
    chk("rst_level", o_level, 0);
    chk("rst_data", o_rd_data, 8'h00);
    // table: rx, byte, rd, flush, level, head, thresh irq (watermark 2)
    tv[0]  = '{1, 8'hA5, 0, 0, 1, 8'hA5, 0};
    tv[1]  = '{1, 8'h3C, 0, 0, 2, 8'hA5, 1};
    tv[2]  = '{1, 8'h7E, 0, 0, 3, 8'hA5, 1};
    tv[3]  = '{0, 8'h00, 1, 0, 2, 8'h3C, 1};
    tv[4]  = '{1, 8'h11, 1, 0, 2, 8'h7E, 1};
    tv[5]  = '{0, 8'h00, 1, 0, 1, 8'h11, 0};
    tv[6]  = '{0, 8'h00, 1, 0, 0, 8'h00, 0};
    tv[7]  = '{0, 8'h00, 1, 0, 0, 8'h00, 0};
    tv[8]  = '{1, 8'h22, 1, 0, 1, 8'h22, 0};
    tv[9]  = '{1, 8'h33, 1, 1, 0, 8'h00, 0};
    tv[10] = '{1, 8'h44, 0, 0, 1, 8'h44, 0};
    i_thresh = 2;
    for (int i = 0; i < 11; i++) begin
      i_rx_dv = tv[i].rx; i_rx_byte = tv[i].b; i_rd_en = tv[i].rd; i_flush = tv[i].fl;
      tick();
      chk("tv_level", o_level, tv[i].lvl);
      chk("tv_data", o_rd_data, tv[i].data);
      chk("tv_empty", o_empty, tv[i].lvl == 0);
      chk("tv_thr", o_thresh_irq, tv[i].thr);
    end
    idle_inputs(); i_thresh = 0;
    // async reset mid-traffic
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(i + 1));
    chk("t1_pre_level", o_level, 5);
    #3 rst_ni = 0;
    #1;
    chk("t1_level", o_level, 0);
    chk("t1_empty", o_empty, 1);
    chk("t1_ovf", o_overflow, 0);
    chk("t1_irq", {o_thresh_irq, o_timeout_irq}, 0);
    @(posedge i_Clock); #1;
    rst_ni = 1;
    q.delete(); m_ovf = 0; m_thr = 0;
    pop();
    chk("t1_pop_level", o_level, 0);
    chk("t1_pop_empty", o_empty, 1);
    // overflow
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hFF);
    chk("t3_full", o_full, 1);
    chk("t3_ovf", o_overflow, 1);
    chk("t3_level", o_level, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain", o_rd_data, i);
      pop();
    end
    chk("t3_empty", o_empty, 1);
    i_clr_ovf = 1; tick(); i_clr_ovf = 0;
    chk("t3_clr", o_overflow, 0);
    // full push+pop, twice so the second pass crosses the pointer wrap
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) push(8'(i));
      i_rx_dv = 1; i_rx_byte = 8'h55; i_rd_en = 1; tick(); idle_inputs();
      chk("t4_level", o_level, 16);
      chk("t4_ovf", o_overflow, 0);
      for (int i = 1; i < 17; i++) begin
        chk("t4_drain", o_rd_data, i == 16 ? 8'h55 : i);
        pop();
      end
      chk("t4_empty", o_empty, 1);
    end
    // watermark
    do_reset();
    i_thresh = 4;
    for (int i = 0; i < 4; i++) begin
      push(8'(i));
      chk("t5_thr", o_thresh_irq, i == 3);
    end
    pop();
    chk("t5_thr_pop", o_thresh_irq, 0);
    i_thresh = 0;
    for (int i = 0; i < 13; i++) push(8'(i));
    chk("t5_thr_off", o_thresh_irq, 0);
    // idle timeout
    do_reset();
    i_timeout_cycles = 100;
    push(8'h9A);
    for (int k = 1; k <= 103; k++) begin
      tick();
      if (k >= 98) chk("t6_tmo", o_timeout_irq, TMO_EN && k >= 101);
    end
    push(8'h9B);
    chk("t6_push_keep", o_timeout_irq, TMO_EN);
    tick();
    chk("t6_push_keep2", o_timeout_irq, TMO_EN);
    pop();
    chk("t6_pop_clr", o_timeout_irq, 0);
    i_timeout_cycles = 0;
    // random traffic against the queue model
    do_reset();
    i_thresh = 5'($urandom_range(1, 16));
    for (int s = 0; s < 10; s++) begin
      pr = (s % 2) ? 80 : 30;
      for (int c = 0; c < 200; c++) begin
        i_rx_dv   = $urandom_range(0, 99) < pr;
        i_rx_byte = 8'($urandom);
        i_rd_en   = $urandom_range(0, 99) < (100 - pr);
        i_flush   = $urandom_range(0, 199) == 0;
        i_clr_ovf = $urandom_range(0, 99) < 5;
        tick();
        chk_model();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
